// File: rtl/smpc_periph_collector_if.sv
// Bus between the SMPC command sequencer / CPU read mux and the peripheral
// collector. The sequencer and CPU side is the master; the collector is the slave.
//
// Request handshake: START, CONT and BREAK are single-cycle strobes.
// The collector samples them only on CE edges and only in the states that
// accept them. There is no ready signal. A strobe that is not accepted is
// dropped, so the master watches BUSY/NEXT/IRQ to see what was accepted.
// OREG_ADDR -> OREG_DO is a free-running read with one CLK of latency.
interface smpc_periph_collector_if #(
  parameter int NUM_PORTS = 2,
  parameter int PAD_BYTES = 2,
  parameter int AW        = 5
);
  logic                             START;
  logic                             CONT;
  logic                             BREAK;
  logic [NUM_PORTS-1:0]             PORT_EN;
  logic [NUM_PORTS*PAD_BYTES*8-1:0] PAD_DATA;
  logic [AW-1:0]                    OREG_ADDR;
  logic [7:0]                       OREG_DO;
  logic                             BUSY;
  logic                             PDE;
  logic                             NEXT;
  logic                             IRQ;

  modport master (
    output START, CONT, BREAK, PORT_EN, PAD_DATA, OREG_ADDR,
    input  OREG_DO, BUSY, PDE, NEXT, IRQ
  );

  modport slave (
    input  START, CONT, BREAK, PORT_EN, PAD_DATA, OREG_ADDR,
    output OREG_DO, BUSY, PDE, NEXT, IRQ
  );
endinterface

// File: rtl/smpc_periph_collector.sv
// SMPC peripheral collector. After a START it waits WAIT_CYCLES CE cycles.
// It then snapshots the port-enable and pad data and streams them in
// Saturn INTBACK format through an OREG_DEPTH-byte page buffer. Further
// pages are requested with CONT, and BREAK abandons the transfer.
module smpc_periph_collector #(
  parameter int NUM_PORTS   = 2,
  parameter int PAD_BYTES   = 2,
  parameter int OREG_DEPTH  = 32,
  parameter int WAIT_CYCLES = 4000,
  parameter int AW          = $clog2(OREG_DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CE,
  smpc_periph_collector_if.slave  bus,
  output logic [2:0]              o_state
);

  localparam int PW = $clog2(NUM_PORTS + 1);   // port index, NUM_PORTS means "stream exhausted"
  localparam int SW = 5;                       // byte-in-port, up to PAD_BYTES+1
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam int DW = NUM_PORTS * PAD_BYTES * 8;
  localparam logic [3:0] PAD_NIBBLE = 4'(PAD_BYTES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT      = 3'd1,
    S_LATCH     = 3'd2,
    S_FILL      = 3'd3,
    S_PAGE_DONE = 3'd4,
    S_HOLD      = 3'd5
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [PW-1:0]           r_port;
  logic [SW-1:0]           r_sub;
  logic [AW-1:0]           r_wptr;
  logic [NUM_PORTS-1:0]    r_en_snap;
  logic [DW-1:0]           r_data_snap;
  logic [OREG_DEPTH*8-1:0] r_oreg;
  logic [7:0]              r_do;
  logic                    r_busy;
  logic                    r_pde;
  logic                    r_next;
  logic                    r_irq;

  logic                    w_done;
  logic                    w_port_conn;
  logic [7:0]              w_data_byte;
  logic [7:0]              w_byte;
  logic [PW-1:0]           w_port_nxt;
  logic [SW-1:0]           w_sub_nxt;
  logic                    w_more;

  // Stream byte at the (port, byte-in-port) pointer, and the pointer that follows it.
  // Byte 0 of a port is the F1/F0 header and byte 1 is the size. Data bytes start at 2.
  always_comb begin
    w_done      = (r_port == PW'(NUM_PORTS));
    w_port_conn = 1'b0;
    w_data_byte = 8'h00;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_port == PW'(p)) begin
        w_port_conn = r_en_snap[p];
        for (int j = 0; j < PAD_BYTES; j++) begin
          if (r_sub == SW'(j + 2)) begin
            w_data_byte = r_data_snap[(p*PAD_BYTES + j)*8 +: 8];
          end
        end
      end
    end

    if (w_done) begin
      w_byte = 8'h00;
    end else if (!w_port_conn) begin
      w_byte = 8'hF0;
    end else if (r_sub == SW'(0)) begin
      w_byte = 8'hF1;
    end else if (r_sub == SW'(1)) begin
      w_byte = {4'h0, PAD_NIBBLE};
    end else begin
      w_byte = w_data_byte;
    end

    w_port_nxt = r_port;
    w_sub_nxt  = r_sub;
    if (!w_done) begin
      if (!w_port_conn || (r_sub == SW'(PAD_BYTES + 1))) begin
        w_port_nxt = r_port + PW'(1);
        w_sub_nxt  = '0;
      end else begin
        w_sub_nxt  = r_sub + SW'(1);
      end
    end
    w_more = (w_port_nxt != PW'(NUM_PORTS));
  end

  // Control FSM. Every output is registered and only advances on CE.
  // Reset overrides CE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_port      <= '0;
      r_sub       <= '0;
      r_wptr      <= '0;
      r_en_snap   <= '0;
      r_data_snap <= '0;
      r_oreg      <= '0;
      r_busy      <= 1'b0;
      r_pde       <= 1'b0;
      r_next      <= 1'b0;
      r_irq       <= 1'b0;
    end else if (CE) begin
      r_irq <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.START) begin
            r_state <= S_WAIT;
            r_cnt   <= CW'(WAIT_CYCLES - 1);
            r_busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.BREAK) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pde   <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= S_LATCH;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_LATCH: begin
          r_en_snap   <= bus.PORT_EN;
          r_data_snap <= bus.PAD_DATA;
          r_port      <= '0;
          r_sub       <= '0;
          r_wptr      <= '0;
          r_state     <= S_FILL;
        end
        S_FILL: begin
          r_oreg[{r_wptr, 3'b000} +: 8] <= w_byte;
          r_port <= w_port_nxt;
          r_sub  <= w_sub_nxt;
          r_wptr <= r_wptr + AW'(1);
          if (r_wptr == AW'(OREG_DEPTH - 1)) begin
            r_state <= S_PAGE_DONE;
            r_irq   <= 1'b1;
            r_pde   <= w_more;
          end
        end
        S_PAGE_DONE: begin
          if (r_pde) begin
            r_state <= S_HOLD;
            r_next  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_HOLD: begin
          // BREAK has priority over CONT.
          if (bus.BREAK) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pde   <= 1'b0;
            r_next  <= 1'b0;
          end else if (bus.CONT) begin
            r_state <= S_FILL;
            r_wptr  <= '0;
            r_next  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_pde   <= 1'b0;
          r_next  <= 1'b0;
        end
      endcase
    end
  end

  // CPU read port. It runs every CLK and ignores CE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_do <= 8'h00;
    end else begin
      r_do <= r_oreg[{bus.OREG_ADDR, 3'b000} +: 8];
    end
  end

  assign bus.OREG_DO = r_do;
  assign bus.BUSY    = r_busy;
  assign bus.PDE     = r_pde;
  assign bus.NEXT    = r_next;
  assign bus.IRQ     = r_irq;
  assign o_state     = r_state;

endmodule

// File: doc/smpc_periph_collector.md
Name: smpc_periph_collector

Overview:
- Parametrised successor to the single-pad INTBACK peripheral path in the SMPC.
- Collects controller data from NUM_PORTS ports, each carrying a PAD_BYTES-byte report, into a Saturn-format byte stream.
- Pages the stream through an OREG_DEPTH-byte output buffer, using the continue/break handshake.
- Sits between the SMPC command sequencer (which drives START/CONT/BREAK) and the CPU read mux (OREG_ADDR/OREG_DO).

Parameters:
NUM_PORTS, 2, number of peripheral ports (1..15)
PAD_BYTES, 2, data bytes per connected peripheral (1..15)
OREG_DEPTH, 32, output buffer bytes per page (power of 2, 4..64)
WAIT_CYCLES, 4000, CE cycles from START to data snapshot
AW, $clog2(OREG_DEPTH), output buffer address width

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active high
CE  in  1  clock enable; all state advance gated by CE except the read path
START  in  1  one-cycle request to begin collection
CONT  in  1  one-cycle request for the next page
BREAK  in  1  one-cycle request to abort collection
PORT_EN  in  NUM_PORTS  1 = peripheral connected on port i
PAD_DATA  in  NUM_PORTS*PAD_BYTES*8  port i byte j at [(i*PAD_BYTES+j)*8 +: 8]; byte 0 is sent first
OREG_ADDR  in  AW  CPU read address
OREG_DO  out  8  registered read data
BUSY  out  1  high whenever state is not IDLE
PDE  out  1  further page pending (SR bit 5)
NEXT  out  1  high in HOLD (SR bit 7 style "data ready")
IRQ  out  1  one-CE-cycle pulse when a page is complete

Behaviour:
- Reset (RST=1 at a CLK edge, regardless of CE):
  - state=IDLE; all OREG entries=0x00.
  - OREG_DO=0, BUSY=0, PDE=0, NEXT=0, IRQ=0.
  - Snapshot and counters cleared.
  - Reset mid-operation aborts without an IRQ.
- Stream format, ports in order 0..NUM_PORTS-1:
  - Connected port: 0xF1, then {4'h0, PAD_BYTES[3:0]}, then PAD_BYTES data bytes.
  - Unconnected port: a single byte, 0xF0.
  - Total length L = sum over ports; L may exceed OREG_DEPTH.
- Read path: OREG_DO <= OREG[OREG_ADDR] every CLK edge, not CE-gated, 1-cycle latency. Reads during FILL return whatever is currently stored; coherence is not guaranteed.
- States:
  - IDLE:
    - START&CE -> WAIT; wait counter loaded with WAIT_CYCLES-1.
    - CONT and BREAK ignored.
  - WAIT:
    - Counter decrements per CE; at 0 -> LATCH.
    - BREAK -> IDLE.
  - LATCH (1 CE cycle):
    - Snapshot PORT_EN and PAD_DATA; stream pointer=0; write pointer=0.
    - -> FILL.
    - Input changes after LATCH do not affect any page.
  - FILL:
    - Each CE cycle writes one byte to OREG[write pointer], always for exactly OREG_DEPTH cycles.
    - While stream pointer < L, the byte written is the stream byte and the stream pointer advances. After the stream is exhausted, the byte written is 0x00.
    - Stream pointer is tracked as (port index, byte-in-port); no multiplier.
    - On the last write -> PAGE_DONE.
    - BREAK is ignored in FILL.
  - PAGE_DONE (1 CE cycle):
    - IRQ=1; PDE=(stream pointer < L).
    - PDE=1 -> HOLD; else -> IDLE.
  - HOLD:
    - NEXT=1.
    - CONT -> FILL, write pointer=0, stream continues, PDE unchanged until the next PAGE_DONE.
    - BREAK -> IDLE, PDE=0.
    - CONT and BREAK in the same cycle: BREAK wins.
- START while BUSY: ignored. START in the same cycle as RST: RST wins.
- IRQ high only in the PAGE_DONE cycle. PDE holds its value through HOLD and clears on entering IDLE.
- Latency: START sampled at CE cycle 0 -> IRQ at CE cycle WAIT_CYCLES+OREG_DEPTH+1. CONT -> IRQ after OREG_DEPTH+1 CE cycles.
- With CE low, the state machine, counters and IRQ freeze. The IRQ pulse is one CE cycle wide, and may span several CLK cycles.

Test Plan:
1. Defaults, PORT_EN=2'b11, PAD_DATA={0x7FFF,0xEFFF} (port0 bytes FF,EF; port1 FF,7F), START.
   - Required: IRQ at CE cycle 4033.
   - OREG[0..7]=F1 02 FF EF F1 02 FF 7F; OREG[8..31]=00.
   - PDE=0; BUSY low the cycle after IRQ.
2. PORT_EN=2'b10, same data.
   - Required: OREG[0..4]=F0 F1 02 FF 7F; rest 00.
3. NUM_PORTS=12, all connected, port i data bytes = {i, ~i} (48-byte stream), WAIT_CYCLES=4.
   - Page 1: ports 0..7 fill OREG[0..31]; PDE=1, NEXT=1.
   - Pulse CONT. Page 2: ports 8..11 in OREG[0..15], OREG[16..31]=00; PDE=0; then IDLE.
4. Same as 3, but in HOLD assert CONT and BREAK together.
   - Required: no further IRQ; IDLE; PDE=0; OREG still holds page 1.
5. Assert RST during FILL at write pointer 10.
   - Required: next cycle BUSY=0, all OREG entries 00, no IRQ.
   - A following START runs normally (repeat scenario 1).
6. CE toggling 1-of-3 during scenario 1 with START re-pulsed while BUSY.
   - Required: identical OREG contents; IRQ at CE cycle 4033; second START ignored.
